// File: rtl/hazard_pkg.sv
// hazard_pkg: FSM state encoding and the stall/flush output patterns shared by hazard_ctrl.
package hazard_pkg;
   typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_ERR} state_e;
   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic id_exe_stall;
      logic exe_mem_stall;
      logic mem_wb_stall;
      logic if_id_flush;
      logic id_exe_flush;
      logic jump;
      logic bus_err;
   } ctrl_t;
   localparam ctrl_t CTRL_IDLE     = 9'b00000_0000;
   localparam ctrl_t CTRL_MEM_WAIT = 9'b11111_0000;
   localparam ctrl_t CTRL_LOAD_USE = 9'b11000_0100;
   localparam ctrl_t CTRL_JUMP     = 9'b00000_1110;
   localparam ctrl_t CTRL_ERR      = 9'b00000_1101;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: saturating 8-bit wait counter; expired_o flags the cycle whose count reaches limit_i.
module mem_wait_timer (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clear_i,
   input  logic       en_i,
   input  logic [7:0] limit_i,
   output logic       expired_o
);
   logic [7:0] cnt_q, cnt_d;
   always_comb cnt_d = clear_i ? 8'd0 : (en_i && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) cnt_q <= 8'd0;
      else cnt_q <= cnt_d;
   // cnt_q counts completed wait cycles, so the current one is the limit_i-th when cnt_q = limit_i-1
   assign expired_o = cnt_q >= limit_i - 8'd1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control for load-use, jumps and memory wait states.
// Optional HAZARD_PERF_CNT_EN adds stall_cnt_o / flush_cnt_o cycle counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int REG_ADDR_W  = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic                  id_rs1_re_i,
   input  logic                  id_rs2_re_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic                  ex_is_load_i,
   input  logic                  jumpe_i,
   input  logic                  mem_req_i,
   input  logic                  mem_ack_i,
   output logic                  pc_stall_o,
   output logic                  if_id_stall_o,
   output logic                  id_exe_stall_o,
   output logic                  exe_mem_stall_o,
   output logic                  mem_wb_stall_o,
   output logic                  if_id_flush_o,
   output logic                  id_exe_flush_o,
   output logic                  jumpe_o,
`ifdef HAZARD_PERF_CNT_EN
   output logic                  bus_err_o,
   output logic [31:0]           stall_cnt_o,
   output logic [31:0]           flush_cnt_o
`else
   output logic                  bus_err_o
`endif
);
   state_e state_q, state_d;
   logic   jump_pend_q, jump_pend_d;
   logic   expired, enter_wait, load_use, jump;
   ctrl_t  ctrl;
   mem_wait_timer u_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (state_q != ST_MEM_WAIT),
      .en_i      (state_q == ST_MEM_WAIT),
      .limit_i   (8'(MEM_TIMEOUT)),
      .expired_o (expired)
   );
   assign enter_wait = mem_req_i & ~mem_ack_i;
   assign load_use   = ex_is_load_i & (|ex_rd_i) &
                       ((id_rs1_re_i & (id_rs1_i == ex_rd_i)) | (id_rs2_re_i & (id_rs2_i == ex_rd_i)));
   // a jump seen while entering the wait is deferred and replayed after the ack
   assign jump       = jump_pend_q | (jumpe_i & ~enter_wait);
   always_comb begin
      state_d     = state_q;
      jump_pend_d = jump_pend_q;
      ctrl        = CTRL_IDLE;
      case (state_q)
         ST_RUN: begin
            ctrl        = jump ? CTRL_JUMP : (load_use & ~jumpe_i) ? CTRL_LOAD_USE : CTRL_IDLE;
            state_d     = enter_wait ? ST_MEM_WAIT : ST_RUN;
            jump_pend_d = jumpe_i & enter_wait;
         end
         ST_MEM_WAIT: begin
            ctrl    = CTRL_MEM_WAIT;
            state_d = mem_ack_i ? ST_RUN : expired ? ST_ERR : ST_MEM_WAIT;
         end
         ST_ERR: begin
            ctrl        = CTRL_ERR;
            state_d     = ST_RUN;
            jump_pend_d = 1'b0;
         end
         default: state_d = ST_RUN;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         state_q     <= ST_RUN;
         jump_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         jump_pend_q <= jump_pend_d;
      end
   assign pc_stall_o      = ctrl.pc_stall;
   assign if_id_stall_o   = ctrl.if_id_stall;
   assign id_exe_stall_o  = ctrl.id_exe_stall;
   assign exe_mem_stall_o = ctrl.exe_mem_stall;
   assign mem_wb_stall_o  = ctrl.mem_wb_stall;
   assign if_id_flush_o   = ctrl.if_id_flush;
   assign id_exe_flush_o  = ctrl.id_exe_flush;
   assign jumpe_o         = ctrl.jump;
   assign bus_err_o       = ctrl.bus_err;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_q + {31'd0, ctrl.pc_stall};
         flush_cnt_q <= flush_cnt_q + {31'd0, ctrl.id_exe_flush};
      end
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`else
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random stimulus against a behavioural model, checked through a scoreboard queue.
module tb_hazard_ctrl;
   localparam int TO = 4;
   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   logic [4:0] id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
   logic id_rs1_re_i = 0, id_rs2_re_i = 0, ex_is_load_i = 0, jumpe_i = 0, mem_req_i = 0, mem_ack_i = 0;
   logic pc_stall_o, if_id_stall_o, id_exe_stall_o, exe_mem_stall_o, mem_wb_stall_o;
   logic if_id_flush_o, id_exe_flush_o, jumpe_o, bus_err_o;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_o, flush_cnt_o;
   int unsigned m_stalls, m_flushes;
`endif
   hazard_ctrl #(.MEM_TIMEOUT(TO), .REG_ADDR_W(5)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rs1_re_i(id_rs1_re_i), .id_rs2_re_i(id_rs2_re_i),
      .ex_rd_i(ex_rd_i), .ex_is_load_i(ex_is_load_i), .jumpe_i(jumpe_i),
      .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
      .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o), .id_exe_stall_o(id_exe_stall_o),
      .exe_mem_stall_o(exe_mem_stall_o), .mem_wb_stall_o(mem_wb_stall_o),
      .if_id_flush_o(if_id_flush_o), .id_exe_flush_o(id_exe_flush_o), .jumpe_o(jumpe_o),
`ifdef HAZARD_PERF_CNT_EN
      .bus_err_o(bus_err_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`else
      .bus_err_o(bus_err_o)
`endif
   );
   always #5 clk_i = ~clk_i;
   logic [8:0] exp_q[$];
   int compared = 0, mismatched = 0, cyc = 0;
   bit m_waiting = 0, m_in_err = 0, m_pend = 0;
   int m_waited = 0;
   // expected pattern bits: pc,if_id,id_exe,exe_mem,mem_wb stalls | if_id,id_exe flushes | jump | bus_err
   task automatic step(input logic r, input logic [4:0] a, input logic [4:0] b, input logic ra,
                       input logic rb, input logic [4:0] d, input logic ld, input logic j,
                       input logic rq, input logic ak);
      bit stall_all, ifid_fl, idex_fl, jo, be, lu_stall, enter, do_jump, lu;
      @(negedge clk_i);
      rst_i = r; id_rs1_i = a; id_rs2_i = b; id_rs1_re_i = ra; id_rs2_re_i = rb;
      ex_rd_i = d; ex_is_load_i = ld; jumpe_i = j; mem_req_i = rq; mem_ack_i = ak;
      if (!r) begin
         m_waiting = 0; m_in_err = 0; m_pend = 0; m_waited = 0;
`ifdef HAZARD_PERF_CNT_EN
         m_stalls = 0; m_flushes = 0;
`endif
      end
      stall_all = 0; ifid_fl = 0; idex_fl = 0; jo = 0; be = 0; lu_stall = 0;
      if (m_waiting) begin
         stall_all = 1;
         if (r) begin
            m_waited++;
            if (ak) m_waiting = 0;
            else if (m_waited == TO) begin m_waiting = 0; m_in_err = 1; end
         end
      end else if (m_in_err) begin
         be = 1; ifid_fl = 1; idex_fl = 1;
         if (r) begin m_in_err = 0; m_pend = 0; end
      end else begin
         enter = rq && !ak;
         do_jump = m_pend || (j && !enter);
         lu = ld && d != 0 && ((ra && a == d) || (rb && b == d));
         if (do_jump) begin jo = 1; ifid_fl = 1; idex_fl = 1; end
         else if (lu && !j) begin lu_stall = 1; idex_fl = 1; end
         if (r) begin
            m_pend = j && enter;
            if (enter) begin m_waiting = 1; m_waited = 0; end
         end
      end
`ifdef HAZARD_PERF_CNT_EN
      if (r) begin
         m_stalls += (stall_all || lu_stall) ? 1 : 0;
         m_flushes += idex_fl ? 1 : 0;
      end
`endif
      exp_q.push_back({stall_all | lu_stall, stall_all | lu_stall, stall_all, stall_all, stall_all,
                       ifid_fl, idex_fl, jo, be});
   endtask
   always @(negedge clk_i) begin
      logic [8:0] e, act;
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         act = {pc_stall_o, if_id_stall_o, id_exe_stall_o, exe_mem_stall_o, mem_wb_stall_o,
                if_id_flush_o, id_exe_flush_o, jumpe_o, bus_err_o};
         compared++;
         if (act !== e) begin
            mismatched++;
            $display("FAIL ctrl_outputs cyc=%0d got=%b want=%b", cyc, act, e);
         end
      end
   end
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   initial begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      step(1, 0, 5, 0, 1, 5, 1, 0, 0, 0);
      idle(1);
      step(1, 5, 0, 1, 0, 5, 1, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      step(1, 5, 5, 0, 0, 5, 1, 0, 0, 0);
      step(1, 0, 5, 0, 1, 5, 1, 1, 0, 0);
      idle(1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(2);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(7);
      step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      idle(1);
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      idle(2);
      step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      idle(6);
      for (int i = 0; i < 3000; i++) begin
         logic [4:0] d;
         d = 5'($urandom_range(0, 3));
         step($urandom_range(0, 99) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), d, 1'($urandom), $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
      end
      idle(1);
      @(negedge clk_i);
      #4;
`ifdef HAZARD_PERF_CNT_EN
      compared++;
      if (stall_cnt_o !== m_stalls || flush_cnt_o !== m_flushes) begin
         mismatched++;
         $display("FAIL perf_cnt got=%0d/%0d want=%0d/%0d", stall_cnt_o, flush_cnt_o, m_stalls, m_flushes);
      end
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum MEM_WAIT cycles before bus error; legal range 1..255.
REQ-002 SHALL have parameter REG_ADDR_W, default 5: register-index width.
REQ-003 SHALL have ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- id_rs1_i, id_rs2_i  in  REG_ADDR_W  source registers of the instruction in ID.
- id_rs1_re_i, id_rs2_re_i  in  1  source-read enables.
- ex_rd_i  in  REG_ADDR_W  destination register of the instruction in EX.
- ex_is_load_i  in  1  EX holds LB/LH/LW/LBU/LHU.
- jumpe_i  in  1  EX branch/jump taken.
- mem_req_i  in  1  MEM stage starts a data access.
- mem_ack_i  in  1  data bus completes the access.
- pc_stall_o, if_id_stall_o, id_exe_stall_o, exe_mem_stall_o, mem_wb_stall_o  out  1  hold stage.
- if_id_flush_o, id_exe_flush_o  out  1  bubble stage.
- jumpe_o  out  1  PC redirect strobe.
- bus_err_o  out  1  one-cycle timeout pulse.

Function
REQ-004 SHALL implement FSM states RUN, MEM_WAIT and ERR.
REQ-005 RUN -> MEM_WAIT when mem_req_i=1 and mem_ack_i=0; RUN stays RUN when both are 1 (zero-wait access).
REQ-006 MEM_WAIT -> RUN on mem_ack_i=1; MEM_WAIT -> ERR when the wait counter reaches MEM_TIMEOUT without ack; ERR -> RUN unconditionally after 1 cycle.
REQ-007 The wait counter SHALL be 8 bits, clear on entry to MEM_WAIT, increment once per MEM_WAIT cycle, and saturate, never wrapping.
REQ-008 In MEM_WAIT, all five stall outputs SHALL be 1 and both flush outputs 0; this is top priority.
REQ-009 Load-use: in RUN with ex_is_load_i=1, ex_rd_i != 0, and id_rsN_i==ex_rd_i with id_rsN_re_i=1, outputs SHALL be pc_stall_o=1, if_id_stall_o=1, id_exe_flush_o=1 for that cycle.
REQ-010 Jump: in RUN with jumpe_i=1, outputs SHALL be jumpe_o=1, if_id_flush_o=1, id_exe_flush_o=1, and all stalls 0, in the same cycle (2-instruction penalty).
REQ-011 Jump and load-use in the same cycle: jump SHALL win; no load-use stall.
REQ-012 A jumpe_i=1 arriving in the cycle that enters MEM_WAIT SHALL be latched in jump_pend_q and replayed per REQ-010 in the first RUN cycle after ack; jumpe_i during MEM_WAIT SHALL be ignored because EX is frozen.
REQ-013 ERR SHALL drive bus_err_o=1, if_id_flush_o=1, id_exe_flush_o=1, all stalls 0, and clear jump_pend_q.
REQ-014 All outputs SHALL be combinational from state, jump_pend_q and inputs; state, counter and jump_pend_q SHALL be registered.

Reset
REQ-015 rst_i=0 SHALL force state=RUN, counter=0, jump_pend_q=0 immediately; all outputs then evaluate to 0 given idle inputs.
REQ-016 Reset during MEM_WAIT SHALL abandon the access with no bus_err_o pulse.

Configuration
REQ-017 With HAZARD_PERF_CNT_EN defined, the block SHALL add 32-bit outputs stall_cnt_o (cycles with pc_stall_o=1) and flush_cnt_o (cycles with id_exe_flush_o=1), wrapping modulo 2^32 and reset to 0; without the macro, these ports and their logic SHALL be absent.

Structure
REQ-018 The FSM state encoding and the stall/flush enable constants SHALL live in shared package hazard_pkg.
REQ-019 The wait counter and its compare SHALL be sub-module mem_wait_timer (inputs clear/enable/limit, output expired).

Verification
REQ-020 Load-use: ex_is_load_i=1, ex_rd_i=5, id_rs2_i=5, id_rs2_re_i=1 -> pc_stall_o=1, if_id_stall_o=1, id_exe_flush_o=1 for exactly 1 cycle.
REQ-021 x0 case: same as REQ-020 with ex_rd_i=0 -> no stall, no flush.
REQ-022 Jump+load-use: jumpe_i=1 in the same cycle as REQ-020 -> jumpe_o=1, both flushes=1, pc_stall_o=0.
REQ-023 Wait state: mem_req_i=1 with mem_ack_i arriving 3 cycles later -> all stalls=1 for 3 cycles, then RUN, bus_err_o never 1.
REQ-024 Timeout: mem_req_i=1, no ack, MEM_TIMEOUT=4 -> 4 stall cycles, bus_err_o=1 for 1 cycle, then RUN.
REQ-025 Pending jump: jumpe_i=1 with mem_req_i=1, ack 2 cycles later -> jumpe_o=1 and flushes=1 in the first RUN cycle; rst_i=0 mid-wait instead -> no jumpe_o and no bus_err_o.
